// File: rtl/adder_arb.sv
// Two-requester 16-bit adder: round-robin arbiter feeding a registered add FSM.
// Latency: req sampled at edge N -> result and ack visible after edge N+1; one op per 3 cycles.
// Backpressure: a requester holds req until its ack pulse; req is ignored while busy.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/req1             add requests, held high until the matching ack
//   a0,b0,cin0 / a1,b1,cin1  per-requester operands and carry-in
//   chain0/chain1         select the requester's saved carry flag as carry-in
//                         (only when ADDARB_CARRY_CHAIN_EN is defined)
//   ack0/ack1             one-cycle completion pulse, mutually exclusive
//   sum, cout, ovf        registered result of the last completed op
//   grant                 index of the requester being or last served
//   busy                  high while an op is in flight (EXEC and DONE)
//
// Build option: define ADDARB_CARRY_CHAIN_EN to add the chain inputs and the
// per-requester carry flags that let an op consume the previous carry-out.

module adder_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        cin0,
    input  logic        cin1,
`ifdef ADDARB_CARRY_CHAIN_EN
    input  logic        chain0,
    input  logic        chain1,
`endif
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Operand latches: captured on the IDLE->EXEC edge so the requester's
    // bus may change freely once the op has been accepted.
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_c;

    logic        r_grant;
    // Last-served requester; a tie goes to the other one.
    logic        r_ptr;

    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_ovf;

`ifdef ADDARB_CARRY_CHAIN_EN
    logic        r_cflag0;
    logic        r_cflag1;
`endif

    logic        w_any_req;
    logic        w_win;
    logic [15:0] w_a_sel;
    logic [15:0] w_b_sel;
    logic        w_cin0_eff;
    logic        w_cin1_eff;
    logic        w_c_sel;
    logic        w_latch;
    logic        w_commit;
    logic [16:0] w_add;
    logic        w_ovf;

    //------------------------------------------------------------------
    // Arbitration
    //------------------------------------------------------------------
    assign w_any_req = req0 | req1;

    always_comb begin
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = ~r_ptr;
        end else if (req1) begin
            w_win = 1'b1;
        end
    end

`ifdef ADDARB_CARRY_CHAIN_EN
    assign w_cin0_eff = chain0 ? r_cflag0 : cin0;
    assign w_cin1_eff = chain1 ? r_cflag1 : cin1;
`else
    assign w_cin0_eff = cin0;
    assign w_cin1_eff = cin1;
`endif

    assign w_a_sel = w_win ? a1 : a0;
    assign w_b_sel = w_win ? b1 : b0;
    assign w_c_sel = w_win ? w_cin1_eff : w_cin0_eff;

    //------------------------------------------------------------------
    // Datapath
    //------------------------------------------------------------------
    assign w_add = {1'b0, r_a} + {1'b0, r_b} + {16'd0, r_c};
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign w_ovf = (r_a[15] == r_b[15]) && (w_add[15] != r_a[15]);

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_commit    = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Operand capture and arbitration state
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 16'd0;
            r_b     <= 16'd0;
            r_c     <= 1'b0;
            r_grant <= 1'b0;
            r_ptr   <= 1'b1;
        end else if (w_latch) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_c     <= w_c_sel;
            r_grant <= w_win;
            r_ptr   <= w_win;
        end
    end

    //------------------------------------------------------------------
    // Result registers: only move on EXEC->DONE, hold otherwise
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 16'd0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_commit) begin
            r_sum  <= w_add[15:0];
            r_cout <= w_add[16];
            r_ovf  <= w_ovf;
        end
    end

`ifdef ADDARB_CARRY_CHAIN_EN
    // Each requester keeps its own carry so chained ops from one requester
    // are not disturbed by interleaved ops from the other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cflag0 <= 1'b0;
            r_cflag1 <= 1'b0;
        end else if (w_commit) begin
            if (r_grant) begin
                r_cflag1 <= w_add[16];
            end else begin
                r_cflag0 <= w_add[16];
            end
        end
    end
`endif

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        busy = 1'b0;
        if (r_state == S_DONE) begin
            ack0 = ~r_grant;
            ack1 = r_grant;
        end
        if (r_state != S_IDLE) begin
            busy = 1'b1;
        end
    end

    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;
    assign grant = r_grant;

endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req0, req1  input  1 each  requester 0/1 add request; held high until matching ack.
REQ-004 a0, b0, a1, b1  input  16 each  per-requester operands; stable while req high.
REQ-005 cin0, cin1  input  1 each  per-requester carry-in.
REQ-006 chain0, chain1  input  1 each  use saved carry instead of cin; present only with ADDARB_CARRY_CHAIN_EN.
REQ-007 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-008 sum  output  16  registered result of last completed op.
REQ-009 cout  output  1  registered carry-out of last completed op.
REQ-010 ovf  output  1  registered two's-complement overflow of last completed op.
REQ-011 grant  output  1  index of the requester being or last served.
REQ-012 busy  output  1  high in EXEC and DONE.

Function
REQ-013 FSM states: IDLE, EXEC, DONE; encoding free.
REQ-014 IDLE: if req0|req1 at edge, latch winner's a, b, effective carry-in; set grant; go to EXEC; else stay.
REQ-015 Arbitration: single request wins; both high -> requester other than last-served pointer wins.
REQ-016 Pointer updates to grant on every IDLE->EXEC transition.
REQ-017 EXEC: compute latched a+b+c (17-bit); register sum=[15:0], cout=[16], ovf=(a[15]==b[15])&&(sum[15]!=a[15]); go to DONE.
REQ-018 DONE: assert ack[grant] for exactly this cycle; other ack low; go to IDLE unconditionally.
REQ-019 Latency: req sampled at edge N -> ack high in cycle after edge N+1; throughput one op per 3 cycles.
REQ-020 req inputs ignored in EXEC and DONE; operand changes after latch edge do not affect result.
REQ-021 req still high at first IDLE edge after ack = new request, arbitrated normally.
REQ-022 sum, cout, ovf hold value until next EXEC->DONE transition.
REQ-023 ack0 and ack1 never high together.

Reset
REQ-024 rst_n low, any state: FSM->IDLE; sum=0, cout=0, ovf=0, ack0=ack1=0, busy=0, grant=0, pointer=1 (first tie goes to requester 0).
REQ-025 Reset in EXEC or DONE aborts op; no ack issued after rst_n release.
REQ-026 First request sampled at first rising edge with rst_n high.

Configuration
REQ-027 Macro ADDARB_CARRY_CHAIN_EN defined: ports chain0/chain1 and per-requester carry flags cflag0/cflag1 exist; effective carry-in = chainN ? cflagN : cinN; cflag[grant] <= cout on EXEC->DONE; other flag unchanged; both flags reset to 0.
REQ-028 Macro undefined: chain ports and flags absent; effective carry-in = cinN always.

Verification
REQ-029 req0, a0=16'h00FF, b0=16'h0001, cin0=0 -> ack0 two cycles after sampled edge, sum=16'h0100, cout=0, ovf=0, grant=0.
REQ-030 After reset, req0 and req1 raised same edge -> requester 0 served first (ack0), req1 held -> ack1 three cycles later; ack pulses never overlap.
REQ-031 a1=16'h7FFF, b1=16'h0001, cin1=0 -> sum=16'h8000, ovf=1, cout=0; a1=16'hFFFF, b1=16'h0001 -> sum=0, cout=1, ovf=0.
REQ-032 rst_n pulsed low during EXEC -> no ack, outputs 0, busy 0; fresh req served normally.
REQ-033 ADDARB_CARRY_CHAIN_EN: req0 FFFF+0001 (cout=1), then req0 chain0=1 0000+0000 -> sum=16'h0001; req1 chain1=1 meanwhile -> uses cflag1=0.
